// File: rtl/timer_pkg.sv
// Shared definitions for the timer: FSM encoding, register offsets, CTRL fields, modes.
// Pure declarations; no latency, no backpressure.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_P_LO    = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Encodings 1x fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: tick_o is high one cycle in every 2^exp_i; clr_i restarts the period.
// Combinational tick from registered count; no backpressure.
module timer_prescaler (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clr_i,
    input  logic [3:0] exp_i,
    output logic       tick_o
);

    logic [14:0] cnt_q;
    logic [14:0] limit;

    // exp_i=15 wraps the shift to zero, so limit becomes all-ones (2^15-1) as required.
    assign limit  = (15'd1 << exp_i) - 15'd1;
    // >= keeps the period bounded if the exponent is lowered mid-period.
    assign tick_o = (cnt_q >= limit);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 15'd1;
        end
    end

endmodule

// File: rtl/timer.sv
// Bus-mapped countdown timer (one-shot / auto-reload) with maskable IRQ; reads are zero-latency,
// writes land on the We edge, no backpressure. Optional prescaler under TIMER_PRESCALE_EN.
module timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Addr,
    input  logic             We,
    input  logic [3:0]       Be,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ
);

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

    state_t           state_q, state_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] be_mask;
    logic [1:0]       mode;
    logic             tick;

    assign mode = ctrl_q[CTRL_MODE_LO +: 2];

    for (genvar g = 0; g < WIDTH; g++) begin : g_be
        assign be_mask[g] = Be[g / 8];
    end

`ifdef TIMER_PRESCALE_EN
    timer_prescaler u_prescaler (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr_i  (state_q == S_LOAD),
        .exp_i  (ctrl_q[CTRL_P_LO +: 4]),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        unique case (state_q)
            S_IDLE: if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                state_d = (preset_q == '0) ? S_INT : S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) state_d = S_INT;
                end
            end
            S_INT: begin
                if (is_reload(mode)) begin
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    pend_d          = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied last so they override same-edge FSM updates.
        if (We) begin
            unique case (Addr)
                ADDR_CTRL: begin
                    if (Be[0]) ctrl_d = Din[7:0] & CTRL_WMASK;
                    pend_d = 1'b0;
                end
                ADDR_PRESET: preset_d = (Din & be_mask) | (preset_q & ~be_mask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        unique case (Addr)
            ADDR_CTRL:   Dout = {{(WIDTH-8){1'b0}}, ctrl_q};
            ADDR_PRESET: Dout = preset_q;
            ADDR_COUNT:  Dout = count_q;
            default:     Dout = '0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & ((state_q == S_INT) | pend_q);

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the timer; expected values are hand-derived from the edge timeline.
module tb_timer;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Addr  = 2'd0;
    logic        We    = 1'b0;
    logic [3:0]  Be    = 4'h0;
    logic [31:0] Din   = '0;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .We    (We),
        .Be    (Be),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        Addr = a; Din = d; Be = b; We = 1'b1;
        tick();
        We = 1'b0; Be = 4'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #2;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_dout addr=%0d got=%h exp=%h", a, v, 32'h0);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        // PRESET=0 one-shot: INT after edge 2, then sticky pend.
        wr(2'd0, 32'h9, 4'hF);
        tick(); tick(); tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_irq got=%b exp=1", IRQ);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_irq got=%b exp=0", IRQ);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_ctrl got=%h exp=%h", v, 32'h0);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (IRQ !== (i >= 7)) begin
                errors++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", i, IRQ, (i >= 7));
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl got=%h exp=%h", v, 32'h8);
        end
        wr(2'd0, 32'h0, 4'hF);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_reload();
        int exp_cnt[5] = '{3, 2, 1, 0, 0};
        int ph;
        do_reset();
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        Addr = 2'd2;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k >= 2) begin
                ph = (k - 2) % 5;
                checks++;
                if (Dout !== 32'(exp_cnt[ph])) begin
                    errors++;
                    $display("FAIL reload_count edge=%0d got=%0d exp=%0d", k, Dout, exp_cnt[ph]);
                end
                checks++;
                if (IRQ !== (ph == 3)) begin
                    errors++;
                    $display("FAIL reload_irq edge=%0d got=%b exp=%b", k, IRQ, (ph == 3));
                end
            end
        end
    endtask

    task automatic test_mask_and_freeze();
        logic [31:0] v;
        int seen;
        do_reset();
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h3, 4'hF);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (IRQ !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mask_irq high_cycles=%0d exp=0", seen);
        end
        do_reset();
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        tick(); tick(); tick(); tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd8) begin
            errors++;
            $display("FAIL freeze_pre got=%0d exp=8", v);
        end
        wr(2'd0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (v !== 32'd7) begin
                errors++;
                $display("FAIL freeze_count step=%0d got=%0d exp=7", i, v);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'h11223344, 4'hF);
        wr(2'd1, 32'h0000AB00, 4'b0010);
        rd(2'd1, v);
        checks++;
        if (v !== 32'h1122AB44) begin
            errors++;
            $display("FAIL be_preset got=%h exp=%h", v, 32'h1122AB44);
        end
        wr(2'd2, 32'hDEADBEEF, 4'hF);
        rd(2'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL count_write got=%h exp=%h", v, 32'h0);
        end
        wr(2'd3, 32'hCAFEF00D, 4'hF);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read got=%h exp=%h", v, 32'h0);
        end
    endtask

    task automatic test_zero_preset();
        do_reset();
        wr(2'd0, 32'h9, 4'hF);
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL zero_edge1 got=%b exp=0", IRQ);
        end
        tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL zero_edge2 got=%b exp=1", IRQ);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        int int_edge;
        do_reset();
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'h29, 4'hF);
`ifdef TIMER_PRESCALE_EN
        int_edge = 14;
        rd(2'd0, v);
        checks++;
        if (v !== 32'h29) begin
            errors++;
            $display("FAIL prescale_ctrl got=%h exp=%h", v, 32'h29);
        end
`else
        int_edge = 5;
        rd(2'd0, v);
        checks++;
        if (v !== 32'h09) begin
            errors++;
            $display("FAIL prescale_ctrl got=%h exp=%h", v, 32'h09);
        end
`endif
        for (int i = 1; i <= int_edge + 1; i++) begin
            tick();
            checks++;
            if (IRQ !== (i >= int_edge)) begin
                errors++;
                $display("FAIL prescale_irq edge=%0d got=%b exp=%b", i, IRQ, (i >= int_edge));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_mask_and_freeze();
        test_byte_enable();
        test_zero_preset();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
